spi_master_shifter: RTL and testbench
=====================================

Name: spi_master_shifter

Overview:
- Master-mode SPI transfer engine downstream of the SPI control register decode.
- Consumes the decoded control bits SPE, MSTR, CPOL, CPHA and LSBFE, accepts one data word per transfer over a valid/ready handshake, and generates SCK, MOSI and SS_n.
- Samples MISO and returns the received word with a one-cycle valid pulse.
- Slave mode is out of scope: with MSTR=0 the block stays idle.

Parameters:
- DATA_W, 8, bits per transfer.
- DIV_W, 8, width of the SCK half-period divider input.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- spe  in  1  SPI enable, from the control register.
- mstr  in  1  master select, from the control register.
- cpol  in  1  SCK idle level.
- cpha  in  1  clock phase.
- lsbfe  in  1  1 = LSB first, 0 = MSB first.
- clk_div  in  DIV_W  SCK half-period is H = clk_div+1 clk cycles.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  combinational; equals (state==IDLE) & spe & mstr.
- rx_data  out  DATA_W  last received word.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- busy  out  1  high in any state other than IDLE.
- sck  out  1  serial clock.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- ss_n  out  1  slave select, active-low.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, sck=0, mosi=0, ss_n=1, rx_data=0, rx_valid=0, busy=0. Reset mid-transfer aborts with no rx_valid.
- States: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - sck is a registered copy of the live cpol input; ss_n=1; mosi=0.
  - A handshake (tx_valid & tx_ready) at cycle 0 does the following: latches tx_data into the shift register; snapshots cpol, cpha, lsbfe and clk_div (later changes to these inputs are ignored until IDLE); clears the edge counter; goes to SETUP.
- SETUP:
  - ss_n=0 from cycle 1; sck=snapshot cpol.
  - If cpha=0, mosi presents the first bit from cycle 1.
  - Lasts H cycles, then goes to SHIFT.
- SHIFT:
  - sck toggles once every H cycles, 2*DATA_W toggles in total. The first toggle is at cycle 1+H.
  - Odd toggles are leading edges; even toggles are trailing edges.
  - cpha=0: sample miso on the leading edge; drive the next bit on the trailing edge (no drive after the final trailing edge).
  - cpha=1: drive a bit on the leading edge; sample miso on the trailing edge.
  - Sampling captures miso in the same clk cycle that the sck toggle is registered.
  - lsbfe=1: shift out bit 0 first and fill rx from the MSB side so received bit 0 = first bit. lsbfe=0: the mirror of this.
  - After the 2*DATA_W-th toggle, sck equals cpol again; go to HOLD.
- HOLD:
  - Lasts H cycles.
  - On its last cycle: rx_data <= assembled word, rx_valid=1, ss_n=1 (registered, visible the next cycle together with rx_valid); state becomes IDLE.
- Latency: rx_valid asserts at cycle 1+(2*DATA_W+1)*H. Example: DATA_W=8, clk_div=0 gives cycle 18.
- Back-to-back: next acceptance is possible at the earliest in the cycle after rx_valid. SS_n stays high for at least one cycle between words.
- tx_valid while busy: ignored (tx_ready=0). No buffering.
- spe or mstr dropping to 0 in SETUP/SHIFT/HOLD: abort to IDLE next cycle. ss_n=1, sck=live cpol, rx_data unchanged, no rx_valid.
- clk_div=0: sck toggles every clk cycle (clk/2). clk_div=max: H=2^DIV_W.
- The divider counter reloads to clk_div on every tick and at SETUP entry. The count is never re-read mid-transfer.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD);
  - default DATA_W and DIV_W;
  - the edge-count width, log2(2*DATA_W)+1.
- Sub-module spi_baud_tick:
  - Down-counter loaded with the snapshot clk_div.
  - Outputs a one-cycle tick every H cycles while enabled.
  - Clears when disabled.
  - Used for the SETUP, SHIFT and HOLD timing.

Test Plan:
- Mode 0, MSB first, clk_div=0, tx_data=0xA5, miso looped to mosi -> ss_n falls at cycle 1; 16 sck toggles; rx_valid at cycle 18; rx_data=0xA5; sck idle 0.
- Mode 3 (cpol=1, cpha=1), lsbfe=1, clk_div=3, tx_data=0x01, miso tied 1 -> sck idles 1; mosi is 1 for only the first bit period; rx_data=0xFF; rx_valid at cycle 1+17*4=69.
- Change cpol and clk_div mid-transfer, mode 1, tx_data=0x3C -> waveform still uses the snapshot values; after return to IDLE, sck follows the new cpol.
- Deassert spe at SHIFT toggle 5 -> ss_n=1 and state IDLE next cycle; no rx_valid; rx_data keeps its previous value; tx_ready=0 until spe=1.
- Hold tx_valid high continuously with tx_data=0x11 then 0x22 -> exactly one acceptance per transfer; ss_n high ≥1 cycle between words; two rx_valid pulses in order.
- Assert rst during SHIFT -> sck=0, ss_n=1, mosi=0 and busy=0 immediately (no clk edge needed); rx_valid never pulses.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master transfer engine:
//   - spi_state_e : transfer FSM states
//   - SPI_DATA_W  : default bits per transfer
//   - SPI_DIV_W   : default width of the SCK half-period divider
//   - spi_edge_w  : width of the SCK edge counter, log2(2*DATA_W)+1
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_DIV_W  = 8;

    // The edge counter must be able to hold the value 2*DATA_W itself.
    function automatic int spi_edge_w(input int data_w);
        return $clog2(2 * data_w) + 1;
    endfunction

    localparam int SPI_EDGE_W = spi_edge_w(SPI_DATA_W);

endpackage

// File: rtl/spi_baud_tick.sv
// -----------------------------------------------------------------------------
// spi_baud_tick
// Half-period timer for the SPI master. A down-counter that produces a
// one-cycle tick every (div+1) clk cycles while enabled.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   en       : count enable; counter clears while low
//   load     : force-load div (start of a transfer)
//   div      : half-period minus one
//   tick     : one-cycle pulse at the end of each half-period
// -----------------------------------------------------------------------------
module spi_baud_tick #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;

    assign tick = en & (cnt_reg == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= div;
        end else if (!en) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= div;
        end else begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_shifter.sv
// -----------------------------------------------------------------------------
// spi_master_shifter
// Master-mode SPI transfer engine. Accepts one word per transfer on a
// valid/ready handshake, drives SCK/MOSI/SS_n and returns the word sampled
// on MISO with a one-cycle rx_valid pulse.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   spe, mstr             : enable / master select (both needed to run)
//   cpol, cpha, lsbfe     : SPI mode and bit order
//   clk_div               : SCK half-period is clk_div+1 clk cycles
//   tx_data/valid/ready   : transmit word handshake
//   rx_data/rx_valid      : received word and its update strobe
//   busy                  : transfer in progress
//   sck, mosi, miso, ss_n : SPI pins
// -----------------------------------------------------------------------------
module spi_master_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int DIV_W  = SPI_DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spe,
    input  logic              mstr,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsbfe,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              ss_n
);

    localparam int EDGE_W = spi_edge_w(DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

    spi_state_e state_reg, state_next;

    logic              cpol_s, cpha_s, lsbfe_s;
    logic [DIV_W-1:0]  div_s;
    logic [EDGE_W-1:0] edge_reg, edge_next;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic              run, accept, tick, toggle, sample, drive, finish;
    logic [DIV_W-1:0]  div_sel;

    assign run      = spe & mstr;
    assign tx_ready = (state_reg == IDLE) & run;
    assign accept   = tx_ready & tx_valid;
    assign busy     = (state_reg != IDLE);

    // The live divider is only looked at for the load at acceptance; after
    // that the timer runs purely from the snapshot.
    assign div_sel = (state_reg == IDLE) ? clk_div : div_s;

    spi_baud_tick #(.DIV_W(DIV_W)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .load (accept),
        .div  (div_sel),
        .tick (tick)
    );

    // Next state plus per-cycle strobes for the datapath.
    always_comb begin
        state_next = state_reg;
        toggle     = 1'b0;
        finish     = 1'b0;
        edge_next  = edge_reg;
        sample     = 1'b0;
        drive      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = SETUP;
            end
            SETUP, SHIFT: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (tick) begin
                    // The tick that ends SETUP is already the first SCK edge.
                    toggle    = 1'b1;
                    edge_next = (state_reg == SETUP) ? EDGE_W'(1) : edge_reg + 1'b1;
                    // edge_next[0]=1 marks a leading edge.
                    sample    = cpha_s ? ~edge_next[0] : edge_next[0];
                    drive     = cpha_s ? edge_next[0]
                                       : (~edge_next[0] & (edge_next != LAST_EDGE));
                    if (edge_next == LAST_EDGE) state_next = HOLD;
                    else                        state_next = SHIFT;
                end
            end
            HOLD: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (tick) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck      <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            cpol_s   <= 1'b0;
            cpha_s   <= 1'b0;
            lsbfe_s  <= 1'b0;
            div_s    <= '0;
            edge_reg <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (state_reg == IDLE) begin
                sck  <= cpol;
                ss_n <= 1'b1;
                mosi <= 1'b0;
                if (accept) begin
                    cpol_s   <= cpol;
                    cpha_s   <= cpha;
                    lsbfe_s  <= lsbfe;
                    div_s    <= clk_div;
                    edge_reg <= '0;
                    rx_sh    <= '0;
                    ss_n     <= 1'b0;
                    if (!cpha) begin
                        // First bit goes out with SS_n; keep the remainder.
                        mosi  <= lsbfe ? tx_data[0] : tx_data[DATA_W-1];
                        tx_sh <= lsbfe ? {1'b0, tx_data[DATA_W-1:1]}
                                       : {tx_data[DATA_W-2:0], 1'b0};
                    end else begin
                        tx_sh <= tx_data;
                    end
                end
            end else if (!run) begin
                sck  <= cpol;
                ss_n <= 1'b1;
                mosi <= 1'b0;
            end else begin
                if (toggle) begin
                    sck      <= ~sck;
                    edge_reg <= edge_next;
                end
                if (sample) begin
                    rx_sh <= lsbfe_s ? {miso, rx_sh[DATA_W-1:1]}
                                     : {rx_sh[DATA_W-2:0], miso};
                end
                if (drive) begin
                    mosi  <= lsbfe_s ? tx_sh[0] : tx_sh[DATA_W-1];
                    tx_sh <= lsbfe_s ? {1'b0, tx_sh[DATA_W-1:1]}
                                     : {tx_sh[DATA_W-2:0], 1'b0};
                end
                if (finish) begin
                    rx_data  <= rx_sh;
                    rx_valid <= 1'b1;
                    ss_n     <= 1'b1;
                    mosi     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_shifter.sv
// -----------------------------------------------------------------------------
// tb_spi_master_shifter
// Directed bench for spi_master_shifter: a vector table of complete
// transfers, followed by hand-written sequences for back-to-back words,
// abort on spe drop and asynchronous reset mid-transfer.
// -----------------------------------------------------------------------------
module tb_spi_master_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic       spe, mstr, cpol, cpha, lsbfe;
    logic [7:0] clk_div;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sck, mosi, miso, ss_n;
    logic [1:0] miso_mode;   // 0: loop MOSI back, 1: tie high, 2: tie low

    int total = 0;
    int bad   = 0;

    assign miso = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1);

    always #5 clk = ~clk;

    spi_master_shifter dut (
        .clk      (clk),
        .rst      (rst),
        .spe      (spe),
        .mstr     (mstr),
        .cpol     (cpol),
        .cpha     (cpha),
        .lsbfe    (lsbfe),
        .clk_div  (clk_div),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .ss_n     (ss_n)
    );

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic       lsbfe;
        logic [7:0] div;
        logic [7:0] tx;
        logic [1:0] miso_mode;
        logic [7:0] exp_rx;
        int         exp_lat;
        logic       chg;       // flip cpol / change clk_div mid-transfer
        logic [7:0] chg_div;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         cyc;
        int         toggles;
        int         nbits;
        logic [7:0] word;
        logic       prev_sck;
        cpol = v.cpol; cpha = v.cpha; lsbfe = v.lsbfe; clk_div = v.div;
        miso_mode = v.miso_mode;
        tx_valid = 1'b0;
        step(); step();
        chk("idle_sck", sck, v.cpol);
        chk("idle_ready", tx_ready, 1'b1);
        tx_data  = v.tx;
        tx_valid = 1'b1;           // cycle 0
        step();                    // cycle 1
        tx_valid = 1'b0;
        chk("ss_fall", ss_n, 1'b0);
        cyc = 1; toggles = 0; nbits = 0; word = 8'h00; prev_sck = sck;
        while (!rx_valid && cyc < 6000) begin
            if (v.chg && cyc == 3) begin
                cpol    = ~v.cpol;
                clk_div = v.chg_div;
            end
            if (sck !== prev_sck) begin
                toggles++;
                // Capture MOSI on the slave's sampling edges.
                if ((toggles % 2 == 1) != v.cpha && nbits < 8) begin
                    if (v.lsbfe) word[nbits]     = mosi;
                    else         word[7 - nbits] = mosi;
                    nbits++;
                end
            end
            prev_sck = sck;
            step();
            cyc++;
        end
        chk("rx_valid_lat", cyc, v.exp_lat);
        chk("rx_data", rx_data, v.exp_rx);
        chk("toggles", toggles, 16);
        chk("mosi_word", word, v.tx);
        chk("ss_end", ss_n, 1'b1);
        chk("busy_end", busy, 1'b0);
        chk("sck_end", sck, v.cpol);
        $display("vec %0d: tx=%02h rx=%02h lat=%0d toggles=%0d", idx, v.tx, rx_data, cyc, toggles);
        step();
        chk("rx_pulse", rx_valid, 1'b0);
        chk("sck_follow", sck, cpol);
    endtask

    initial begin
        int         cyc;
        int         toggles;
        int         acc;
        int         rxv;
        int         gap;
        int         pulses;
        logic       hs;
        logic       prev_sck;
        logic [7:0] first_rx, second_rx;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'hA5, 2'd0, 8'hA5, 18,   1'b0, 8'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'd3,   8'h01, 2'd1, 8'hFF, 69,   1'b0, 8'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'd1,   8'h3C, 2'd0, 8'h3C, 35,   1'b1, 8'd5};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 8'd2,   8'h96, 2'd2, 8'h00, 52,   1'b0, 8'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'd0,   8'h80, 2'd0, 8'h80, 18,   1'b0, 8'd0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 8'd255, 8'h5A, 2'd0, 8'h5A, 4353, 1'b0, 8'd0};

        rst = 1'b1; spe = 1'b0; mstr = 1'b0; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
        clk_div = 8'd0; tx_data = 8'h00; tx_valid = 1'b0; miso_mode = 2'd0;
        step(); step();
        chk("rst_sck", sck, 1'b0);
        chk("rst_ss", ss_n, 1'b1);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // Slave mode: stays idle even with a word offered.
        spe = 1'b1; mstr = 1'b0; tx_data = 8'h55; tx_valid = 1'b1;
        step();
        chk("slave_ready", tx_ready, 1'b0);
        step(); step();
        chk("slave_busy", busy, 1'b0);
        chk("slave_ss", ss_n, 1'b1);
        tx_valid = 1'b0;
        mstr = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back with tx_valid held high.
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; clk_div = 8'd0; miso_mode = 2'd0;
        step();
        tx_data = 8'h11; tx_valid = 1'b1;
        acc = 0; rxv = 0; gap = 0; first_rx = 8'h00; second_rx = 8'h00; cyc = 0;
        while (rxv < 2 && cyc < 200) begin
            if (rx_valid) begin
                rxv++;
                if (rxv == 1) first_rx = rx_data;
                else          second_rx = rx_data;
            end
            if (rxv == 1 && ss_n) gap++;
            hs = tx_valid & tx_ready;
            if (hs) acc++;
            step();
            cyc++;
            if (hs && acc == 1) tx_data = 8'h22;
            if (hs && acc == 2) tx_valid = 1'b0;
        end
        chk("b2b_accepts", acc, 2);
        chk("b2b_pulses", rxv, 2);
        chk("b2b_first", first_rx, 8'h11);
        chk("b2b_second", second_rx, 8'h22);
        chk("b2b_ss_gap", (gap >= 1), 1'b1);
        $display("b2b: accepts=%0d rx=%02h,%02h ss_gap=%0d", acc, first_rx, second_rx, gap);
        tx_valid = 1'b0;

        // Abort by dropping spe at the fifth SCK toggle.
        clk_div = 8'd1;
        step(); step();
        tx_data = 8'h77; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        toggles = 0; cyc = 0; prev_sck = sck;
        while (toggles < 5 && cyc < 200) begin
            step();
            cyc++;
            if (sck !== prev_sck) toggles++;
            prev_sck = sck;
        end
        chk("abort_reach", toggles, 5);
        spe = 1'b0;
        step();
        chk("abort_ss", ss_n, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", tx_ready, 1'b0);
        chk("abort_sck", sck, cpol);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (rx_valid) pulses++;
            step();
        end
        chk("abort_no_rx", pulses, 0);
        chk("abort_rx_keep", rx_data, 8'h22);
        chk("abort_ready_hold", tx_ready, 1'b0);
        spe = 1'b1;
        #1;
        chk("abort_ready_back", tx_ready, 1'b1);
        $display("abort: ss_n=%0b busy=%0b rx_data=%02h", ss_n, busy, rx_data);

        // Asynchronous reset in SHIFT, mode 3 with all-ones data.
        cpol = 1'b1; cpha = 1'b1; lsbfe = 1'b0; clk_div = 8'd2; miso_mode = 2'd1;
        step(); step();
        tx_data = 8'hFF; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        toggles = 0; cyc = 0; prev_sck = sck;
        while (toggles < 3 && cyc < 200) begin
            step();
            cyc++;
            if (sck !== prev_sck) toggles++;
            prev_sck = sck;
        end
        chk("rst_pre_mosi", mosi, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sck", sck, 1'b0);
        chk("arst_ss", ss_n, 1'b1);
        chk("arst_mosi", mosi, 1'b0);
        chk("arst_busy", busy, 1'b0);
        pulses = 0;
        step();
        if (rx_valid) pulses++;
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rx_valid) pulses++;
            step();
        end
        chk("arst_no_rx", pulses, 0);
        chk("arst_rx_data", rx_data, 8'h00);
        $display("async reset: sck=%0b ss_n=%0b busy=%0b", sck, ss_n, busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
